// File: rtl/mux4_rr_arbiter_if.sv
// Purpose: handshake bundle between four requesters and the 4:1 mux arbiter.
// Latency: none, wires only.
// Backpressure: requesters hold req until granted; owner releases with done.
// Ports: req[3:0], done (requester side -> arbiter); gnt[3:0], sel[1:0],
//        busy, timeout_err (arbiter -> requester side).
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout_err;

  // Requester / datapath side.
  modport master (
    output req,
    output done,
    input  gnt,
    input  sel,
    input  busy,
    input  timeout_err
  );

  // Arbiter side.
  modport slave (
    input  req,
    input  done,
    output gnt,
    output sel,
    output busy,
    output timeout_err
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Purpose: round-robin arbiter/sequencer for the shared 4:1 64-bit word mux, with hold watchdog.
// Latency: grant visible one edge after req is sampled in IDLE; one idle cycle between owners.
// Backpressure: non-owners wait with req held; owner keeps the grant until done, req drop or timeout.
// Ports: clk, rst_n (async active-low); bus (slave modport): req, done in; gnt, sel, busy, timeout_err out.
module mux4_rr_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  mux4_rr_arbiter_if.slave           bus
);

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);
  localparam bit         TO_EN  = (TIMEOUT != 0);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state;
  logic [3:0] gnt_q;
  logic [1:0] sel_q;
  logic       timeout_err_q;
  logic [1:0] ptr;
  logic [7:0] cnt;

  logic [1:0] win;
  logic [1:0] idx;
  logic       owner_req;
  logic       to_hit;

  // Scan from ptr+3 down to ptr so the lowest rotation offset is written last
  // and therefore wins.
  always_comb begin
    win = ptr;
    idx = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (bus.req[idx]) begin
        win = idx;
      end
    end
  end

  // While BUSY, sel_q holds the owner index.
  assign owner_req = bus.req[sel_q];
  assign to_hit    = TO_EN && (cnt == TO_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      gnt_q         <= 4'b0000;
      sel_q         <= 2'b00;
      timeout_err_q <= 1'b0;
      ptr           <= 2'b00;
      cnt           <= 8'd0;
    end else begin
      timeout_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            gnt_q <= 4'b0001 << win;
            sel_q <= win;
            cnt   <= 8'd1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (bus.done || !owner_req || to_hit) begin
            gnt_q         <= 4'b0000;
            ptr           <= sel_q + 2'd1;
            state         <= IDLE;
            // Only a pure watchdog release flags an error; done or a
            // dropped request take precedence.
            timeout_err_q <= !bus.done && owner_req && to_hit;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt_q <= 4'b0000;
        end
      endcase
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.sel         = sel_q;
  assign bus.busy        = |gnt_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer for the shared 4:1 64-bit word mux in the datapath. Four requesters compete for the mux output (and the resource behind it); the block grants exactly one at a time, drives the mux `sel[1:0]`, and holds the grant until the owner signals completion. A watchdog forcibly releases an owner that holds the resource too long.

## Interface
- `TIMEOUT`, default 255: maximum number of BUSY cycles before forced release. Range 1..255. 0 disables the watchdog.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `req`  in  4  per-requester request, level-sensitive, held until serviced.
- `done`  in  1  completion pulse from the current owner; sampled only in BUSY.
- `gnt`  out  4  one-hot grant, registered; all-zero when idle.
- `sel`  out  2  mux select, the binary index of the current or last owner; registered.
- `busy`  out  1  high while a grant is active (equals `|gnt`).
- `timeout_err`  out  1  one-cycle pulse after a forced release.

## Operation
- There are two states, IDLE and BUSY. There is also a round-robin pointer `ptr[1:0]`, which is the highest-priority index, and an 8-bit hold counter `cnt`.
- Reset values: state=IDLE, `gnt`=0000, `sel`=00, `busy`=0, `timeout_err`=0, `ptr`=0, `cnt`=0.
- IDLE:
  - If `req`≠0, pick the first asserted bit scanning `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 (mod 4). Call it winner W.
  - At the edge: `gnt`←onehot(W), `sel`←W, `cnt`←1, go to BUSY.
  - If `req`=0, stay in IDLE. `sel` holds its value.
- BUSY, evaluated each cycle in priority order:
  1. `done`=1 → normal release.
  2. `req[W]`=0 → abort release, no error.
  3. `TIMEOUT`≠0 and `cnt`==`TIMEOUT` → forced release. `timeout_err`=1 in the next cycle.
  4. Otherwise `cnt`←`cnt`+1, saturating at 255.
- Any release: `gnt`←0000, `ptr`←W+1 (mod 4, wraps 3→0), state←IDLE. `sel` keeps W.
- `done` in IDLE is ignored.
- Requests from non-owners during BUSY are ignored and must stay asserted to be served later.
- Reset asserted mid-transaction: all outputs and state return to reset values immediately (asynchronously), and the pointer returns to 0.

## Timing
- Grant latency: `req` sampled high at edge N with the block IDLE → `gnt`/`sel` valid after edge N.
- Mandatory turnaround: after a release at edge M, the block is IDLE for the cycle after M. The next grant is visible after edge M+1. Back-to-back owners are therefore separated by one idle cycle with `gnt`=0.
- `sel` changes only on a grant edge, so the mux output is stable during the idle gap.
- `done` asserted in W's first BUSY cycle releases at the next edge. The minimum grant length is 1 cycle.
- Timeout: with `TIMEOUT`=T and no `done`, `gnt` is high for exactly T cycles. `timeout_err` is high for exactly 1 cycle, coinciding with the idle turnaround cycle.
- `done` and the timeout condition in the same cycle → treated as a normal release, `timeout_err` stays 0.
- `gnt` is always one-hot or zero. `busy` = `|gnt`, with no separate latency.

## Test plan
- Reset, then `req`=0100 → after the next edge `gnt`=0100, `sel`=10, `busy`=1. Pulse `done` → `gnt`=0000 next cycle and `ptr` becomes 3.
- After reset, hold `req`=1111 continuously and pulse `done` on every owner's 2nd BUSY cycle → grant order 0,1,2,3,0, each owner held 2 cycles with 1 idle cycle between owners.
- Owner 3 releases while `req`=1001 → the pointer wraps to 0 and the next grant is 0001, not 1000.
- `TIMEOUT`=4, `req`=0010 held, no `done` → `gnt`=0010 for exactly 4 cycles, then `timeout_err`=1 for 1 cycle while `gnt`=0000, then `gnt`=0010 regranted.
- `TIMEOUT`=4, `done` asserted in the 4th BUSY cycle → release with `timeout_err`=0. Separately, the owner drops `req` mid-grant → release next edge with `timeout_err`=0.
- While BUSY with `sel`=11, assert `rst_n`=0 asynchronously between edges → `gnt`=0000, `sel`=00, `busy`=0 immediately. Release reset with `req`=1010 → first grant is 0010.
